// File: rtl/mem_arbiter_if.sv
// Shared main-memory port bundle: two cache requesters plus the memory side.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_SIZE     = 128
);
    logic [1:0]                 req_enable;
    logic [1:0]                 req_op;
    logic [2*ADDRESS_WIDTH-1:0] req_address;
    logic [2*LINE_SIZE-1:0]     req_data_in;
    logic [1:0]                 req_op_done;
    logic [LINE_SIZE-1:0]       req_data_out;
    logic [1:0]                 req_data_ready;
    logic [1:0]                 req_in_use;
    logic                       mem_enable;
    logic                       mem_op;
    logic [ADDRESS_WIDTH-1:0]   mem_address;
    logic [LINE_SIZE-1:0]       mem_data_in;
    logic                       mem_data_ready;
    logic [LINE_SIZE-1:0]       mem_data_out;

    modport slave (
        input  req_enable, req_op, req_address, req_data_in, req_op_done,
        input  mem_data_ready, mem_data_out,
        output req_data_out, req_data_ready, req_in_use,
        output mem_enable, mem_op, mem_address, mem_data_in
    );

    modport master (
        output req_enable, req_op, req_address, req_data_in, req_op_done,
        output mem_data_ready, mem_data_out,
        input  req_data_out, req_data_ready, req_in_use,
        input  mem_enable, mem_op, mem_address, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (port 0 icache, port 1 dcache) for the line-wide memory port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate on simultaneous requests; default is port 1 priority.
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_SIZE     = 128
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     last_grant_q, last_grant_d;
    logic                     dropped_q, dropped_d;
    logic                     enable_q, enable_d;
    logic                     op_q, op_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [LINE_SIZE-1:0]     wdata_q, wdata_d;
    logic [LINE_SIZE-1:0]     rdata_q, rdata_d;
    logic [1:0]               ready_q, ready_d;
    logic [1:0]               in_use_q, in_use_d;
    logic                     winner;

    // Pick the port to grant from the current request vector.
    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (&bus.req_enable)
            winner = ~last_grant_q;
        else
            winner = bus.req_enable[1];
`else
        winner = bus.req_enable[1];
`endif
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        dropped_d    = dropped_q;
        enable_d     = enable_q;
        op_d         = op_q;
        address_d    = address_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ready_d      = ready_q;
        in_use_d     = in_use_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_enable) begin
                    grant_d   = winner;
                    dropped_d = 1'b0;
                    enable_d  = 1'b1;
                    op_d      = bus.req_op[winner];
                    address_d = winner
                        ? bus.req_address[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                        : bus.req_address[ADDRESS_WIDTH-1:0];
                    wdata_d   = winner
                        ? bus.req_data_in[2*LINE_SIZE-1:LINE_SIZE]
                        : bus.req_data_in[LINE_SIZE-1:0];
                    in_use_d  = winner ? 2'b01 : 2'b10;
                    state_d   = MEM;
                end
            end
            MEM: begin
                // A requester that withdraws at any point in MEM gets no response.
                dropped_d = dropped_q | ~bus.req_enable[grant_q];
                if (bus.mem_data_ready) begin
                    enable_d = 1'b0;
                    if (!op_q)
                        rdata_d = bus.mem_data_out;
                    if (dropped_d) begin
                        in_use_d     = 2'b00;
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        ready_d[grant_q] = 1'b1;
                        state_d          = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.req_op_done[grant_q]) begin
                    ready_d      = 2'b00;
                    in_use_d     = 2'b00;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                grant_d      = 1'b0;
                last_grant_d = 1'b0;
                dropped_d    = 1'b0;
                enable_d     = 1'b0;
                op_d         = 1'b0;
                address_d    = '0;
                wdata_d      = '0;
                rdata_d      = '0;
                ready_d      = 2'b00;
                in_use_d     = 2'b00;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            dropped_q    <= 1'b0;
            enable_q     <= 1'b0;
            op_q         <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ready_q      <= 2'b00;
            in_use_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            dropped_q    <= dropped_d;
            enable_q     <= enable_d;
            op_q         <= op_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            in_use_q     <= in_use_d;
        end
    end

    assign bus.mem_enable     = enable_q;
    assign bus.mem_op         = op_q;
    assign bus.mem_address    = address_q;
    assign bus.mem_data_in    = wdata_q;
    assign bus.req_data_out   = rdata_q;
    assign bus.req_data_ready = ready_q;
    assign bus.req_in_use     = in_use_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-vector bench for mem_arbiter: each record is applied before a clock
// edge and the registered outputs are compared just after that edge.
module tb_mem_arbiter;

    localparam logic [31:0]  A0  = 32'h0000_0040;
    localparam logic [31:0]  A1  = 32'h0000_0080;
    localparam logic [127:0] P0D = {4{32'h0123_4567}};
    localparam logic [127:0] L1  = {4{32'hDEAD_BEEF}};
    localparam logic [127:0] L0  = 128'h100f0e0d_0c0b0a09_08070605_04030201;
    localparam logic [127:0] L2  = {4{32'hA5A5_5A5A}};
    localparam logic [127:0] G   = {4{32'hCAFE_F00D}};

    typedef struct {
        logic [1:0]   en;
        logic [1:0]   op;
        logic [1:0]   done;
        logic         mrdy;
        logic [127:0] mout;
        logic         men;
        logic         mop;
        logic [31:0]  maddr;
        logic [127:0] mdin;
        logic [1:0]   rdy;
        logic [1:0]   use_;
        logic [127:0] rout;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int nvec = 0;
    int nbad = 0;
    vec_t q[$];
    logic [127:0] cur_rout;

    mem_arbiter_if #(.ADDRESS_WIDTH(32), .LINE_SIZE(128)) bus ();

    mem_arbiter #(.ADDRESS_WIDTH(32), .LINE_SIZE(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [1:0] en, input logic [1:0] op, input logic [1:0] done,
        input logic mrdy, input logic [127:0] mout,
        input logic men, input logic mop, input logic [31:0] maddr,
        input logic [127:0] mdin, input logic [1:0] rdy,
        input logic [1:0] use_, input logic [127:0] rout);
        vec_t v;
        v.en = en; v.op = op; v.done = done; v.mrdy = mrdy; v.mout = mout;
        v.men = men; v.mop = mop; v.maddr = maddr; v.mdin = mdin;
        v.rdy = rdy; v.use_ = use_; v.rout = rout;
        return v;
    endfunction

    // One full transaction for port g: grant edge, wait edges, memory-ready
    // edge, op_done edge. Expected values follow from g and the op.
    task automatic add_txn(input bit g, input logic [1:0] en,
                           input logic [1:0] op, input logic [127:0] mout,
                           input int waits, input logic [1:0] wdone,
                           input logic [1:0] en_after);
        logic [31:0]  a;
        logic [127:0] d;
        logic [127:0] nr;
        logic [1:0]   u;
        logic [1:0]   gb;
        a  = g ? A1 : A0;
        d  = g ? L1 : P0D;
        u  = g ? 2'b01 : 2'b10;
        gb = g ? 2'b10 : 2'b01;
        nr = op[g] ? cur_rout : mout;
        q.push_back(mk(en, op, 2'b00, 1'b0, '0,
                       1'b1, op[g], a, d, 2'b00, u, cur_rout));
        for (int i = 0; i < waits; i++)
            q.push_back(mk(en, op, wdone, 1'b0, '0,
                           1'b1, op[g], a, d, 2'b00, u, cur_rout));
        q.push_back(mk(en, op, 2'b00, 1'b1, mout,
                       1'b0, op[g], a, d, gb, u, nr));
        q.push_back(mk(en_after, op, gb, 1'b0, '0,
                       1'b0, op[g], a, d, 2'b00, 2'b00, nr));
        cur_rout = nr;
    endtask

    task automatic drive(input vec_t v);
        bus.req_enable     = v.en;
        bus.req_op         = v.op;
        bus.req_op_done    = v.done;
        bus.mem_data_ready = v.mrdy;
        bus.mem_data_out   = v.mout;
    endtask

    task automatic check(input string name, input vec_t v);
        nvec++;
        if (bus.mem_enable !== v.men || bus.mem_op !== v.mop ||
            bus.mem_address !== v.maddr || bus.mem_data_in !== v.mdin ||
            bus.req_data_ready !== v.rdy || bus.req_in_use !== v.use_ ||
            bus.req_data_out !== v.rout) begin
            nbad++;
            $display("FAIL %s: got men=%b mop=%b addr=%h rdy=%b use=%b mdin=%h rout=%h; want men=%b mop=%b addr=%h rdy=%b use=%b mdin=%h rout=%h",
                     name, bus.mem_enable, bus.mem_op, bus.mem_address,
                     bus.req_data_ready, bus.req_in_use, bus.mem_data_in,
                     bus.req_data_out, v.men, v.mop, v.maddr, v.rdy, v.use_,
                     v.mdin, v.rout);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check(name, v);
        @(negedge clk);
    endtask

    initial begin
        vec_t z;
        vec_t v;
        bit   g;
        cur_rout = '0;

        // Port 0 read; op_done from port 1 while in MEM is ignored.
        add_txn(1'b0, 2'b01, 2'b00, L0, 2, 2'b10, 2'b00);
        // Port 1 write; grantee op_done in MEM is ignored, no read capture.
        add_txn(1'b1, 2'b10, 2'b10, G, 1, 2'b10, 2'b00);
        // Simultaneous reads: winner first, loser in the next IDLE.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        g = 1'b0;
`else
        g = 1'b1;
`endif
        add_txn(g, 2'b11, 2'b00, L2, 0, 2'b00, g ? 2'b01 : 2'b10);
        add_txn(~g, g ? 2'b01 : 2'b10, 2'b00, L0, 0, 2'b00, 2'b00);
        // Port 0 write withdrawn during MEM: no response, straight to IDLE.
        q.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, '0,
                       1'b1, 1'b1, A0, P0D, 2'b00, 2'b10, cur_rout));
        q.push_back(mk(2'b00, 2'b01, 2'b00, 1'b0, '0,
                       1'b1, 1'b1, A0, P0D, 2'b00, 2'b10, cur_rout));
        q.push_back(mk(2'b00, 2'b01, 2'b00, 1'b1, G,
                       1'b0, 1'b1, A0, P0D, 2'b00, 2'b00, cur_rout));
        q.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, '0,
                       1'b0, 1'b1, A0, P0D, 2'b00, 2'b00, cur_rout));
        // Both requesting continuously for four transactions.
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            g = (k % 2 == 0);
`else
            g = 1'b1;
`endif
            add_txn(g, 2'b11, 2'b00, g ? L2 : L0, 0, 2'b00, 2'b11);
        end

        z = mk(2'b00, 2'b00, 2'b00, 1'b0, '0,
               1'b0, 1'b0, '0, '0, 2'b00, 2'b00, '0);
        drive(z);
        bus.req_address = {A1, A0};
        bus.req_data_in = {L1, P0D};
        #1;
        check("reset_async", z);
        @(posedge clk);
        #1;
        check("reset_held", z);
        @(negedge clk);
        reset = 1'b0;

        foreach (q[i])
            step($sformatf("vec%0d", i), q[i]);

        // Reset pulse in MEM, then the still-pending request is re-granted.
        step("rst_mem_enter", mk(2'b01, 2'b00, 2'b00, 1'b0, '0,
             1'b1, 1'b0, A0, P0D, 2'b00, 2'b10, cur_rout));
        reset = 1'b1;
        #1;
        check("rst_mem_abort", z);
        @(negedge clk);
        reset = 1'b0;
        step("rst_regrant", mk(2'b01, 2'b00, 2'b00, 1'b0, '0,
             1'b1, 1'b0, A0, P0D, 2'b00, 2'b10, '0));
        step("rst_resp", mk(2'b01, 2'b00, 2'b00, 1'b1, L2,
             1'b0, 1'b0, A0, P0D, 2'b01, 2'b10, L2));
        v = mk(2'b00, 2'b00, 2'b01, 1'b0, '0,
               1'b0, 1'b0, A0, P0D, 2'b00, 2'b00, L2);
        step("rst_done", v);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter sharing the single line-wide main-memory port between the instruction cache (port 0) and the data cache (port 1).
- Grants one requester at a time and latches its op, address and line data.
- Sequences the memory transaction and returns the line together with a ready handshake.
- Holds the grant until the requester acknowledges with op_done.
- Drives per-requester memory_in_use so the cache that is not granted stalls.

Parameters:
ADDRESS_WIDTH, 32, memory address width
LINE_SIZE, 128, line width in bits (memory transfer unit)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_enable  input  2  per-requester memory request (bit i = requester i)
req_op  input  2  per-requester op, 0 = read line, 1 = write line
req_address  input  2*ADDRESS_WIDTH  requester i address at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
req_data_in  input  2*LINE_SIZE  requester i write line at [i*LINE_SIZE +: LINE_SIZE]
req_op_done  input  2  requester i has consumed the response; releases the grant
req_data_out  output  LINE_SIZE  read line returned to the granted requester
req_data_ready  output  2  response valid for requester i
req_in_use  output  2  memory busy serving the other requester
mem_enable  output  1  memory request
mem_op  output  1  latched op to memory
mem_address  output  ADDRESS_WIDTH  latched address to memory
mem_data_in  output  LINE_SIZE  latched write line to memory
mem_data_ready  input  1  memory finished the op; mem_data_out valid for reads
mem_data_out  input  LINE_SIZE  line read from memory

Behaviour:
- Reset:
  - State IDLE, grant = 0, last_grant = 0.
  - All outputs 0: mem_enable, mem_op, mem_address, mem_data_in, req_data_out, req_data_ready, req_in_use.
  - Reset asserted mid-transaction aborts immediately. The memory sees mem_enable fall; no response is delivered.
- IDLE:
  - If any req_enable bit is set, select the winner per the arbitration rule and set grant.
  - Latch that requester's op, address and data into mem_op/mem_address/mem_data_in.
  - Set mem_enable = 1 and move to MEM.
  - Latency: request sampled at edge N gives mem_enable high after edge N.
- MEM:
  - Hold mem_* stable.
  - On mem_data_ready = 1: capture mem_data_out into req_data_out (reads only; writes leave it unchanged), set mem_enable = 0, set req_data_ready[grant] = 1, move to RESP.
- RESP:
  - Hold req_data_ready[grant] and req_data_out stable until req_op_done[grant] = 1.
  - Then clear req_data_ready, update last_grant = grant and return to IDLE.
  - Minimum one IDLE cycle between grants, so back-to-back grants are 1 bubble apart.
- req_in_use[i] = 1 whenever state is not IDLE and grant differs from i. It is registered and changes on the same edge as the state.
- Grantee drops req_enable during MEM: the memory op still completes (no abort). req_data_ready is suppressed and the FSM goes straight from MEM to IDLE.
- req_op_done from the non-granted requester is ignored. req_op_done from the grantee in MEM is ignored.
- Arbitration without the optional feature: fixed priority, port 1 (dcache) beats port 0 (icache) when both request in the same IDLE cycle.
- Invalid state encoding returns to IDLE with outputs cleared.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests the winner is the port not equal to last_grant. A single request wins regardless of last_grant.
- Undefined: fixed priority as above; last_grant is still maintained but unused.

Test Plan:
1. Port 0 read, addr 0x0000_0040; memory returns mem_data_ready 3 cycles later with line 0x..0403_0201 -> mem_op = 0 and mem_address = 0x40 one cycle after request; req_data_ready = 2'b01 with that line; req_in_use = 2'b10 throughout; released after req_op_done[0].
2. Port 1 write, addr 0x0000_0080, line 0xDEAD_BEEF repeated -> mem_op = 1 and mem_data_in equal to that line; req_data_ready[1] = 1 after mem_data_ready; req_data_out unchanged.
3. Both request in the same cycle, fixed priority -> port 1 granted first and req_in_use[0] = 1; port 0 granted in the first IDLE after port 1's op_done.
4. MEM_ARB_ROUND_ROBIN_EN, both requesting continuously for 4 transactions -> grant order 1, 0, 1, 0 with last_grant = 0 after reset.
5. Reset pulse while in MEM -> all outputs 0 immediately (asynchronous); the pending request is re-arbitrated after reset deasserts.
6. Grantee drops req_enable during MEM -> mem_data_ready still consumed; no req_data_ready pulse; FSM is back in IDLE on the next cycle.
